uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx instance between N_REQ byte sources (rom_fetcher-style streams, debug dumpers).
//  Round-robin arbitration; drives uart_tx start/transmit_data and tracks the ready handshake.
//  Message lock keeps a multi-byte message unbroken on the line; burst cap and lock timeout bound starvation.
// PARAMETERS
//  N_REQ         2    number of requesters (>=2)
//  DATA_WIDTH    8    byte width, equal to uart_tx DATA_WIDTH
//  MAX_BURST     16   max bytes one owner sends back-to-back before forced re-arbitration
//  LOCK_TIMEOUT  64   IDLE cycles a locked owner may hold req_valid low before the lock is dropped
// PORTS
//  clk        in   1                 system clock, all logic on posedge
//  rst_n      in   1                 reset, asynchronous, active-low
//  req_valid  in   N_REQ             requester i has a byte on req_data
//  req_data   in   N_REQ*DATA_WIDTH  byte of requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_last   in   N_REQ             byte of requester i is the last of its message
//  req_ack    out  N_REQ             1-cycle pulse: byte of requester i taken; it may change data next cycle
//  tx_ready   in   1                 uart_tx ready (high = idle, may accept start)
//  tx_start   out  1                 1-cycle start pulse to uart_tx
//  tx_data    out  DATA_WIDTH        registered byte to uart_tx transmit_data, stable START..WAIT_DONE
//  busy       out  1                 high in every state except IDLE
//  grant_id   out  max(1,clog2(N_REQ))  index of current/last owner
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; tx_start=0, tx_data=0, req_ack=0, busy=0, grant_id=0,
//   rr pointer=0, lock=0, burst count=0, timeout count=0. Assert mid-frame: aborts at once, no ack replay.
//  FSM: IDLE -> START -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//  IDLE: unlocked and tx_ready=1 and |req_valid: winner = first valid index at or after rr pointer
//   (wrapping N_REQ-1 -> 0). Same edge: tx_data<=req_data[winner], req_ack[winner]=1, grant_id<=winner,
//   rr pointer<=winner+1 mod N_REQ, go START.
//  IDLE locked: only owner grant_id considered; other requesters are ignored. Owner valid and tx_ready
//   -> take byte as above (pointer unchanged). Owner valid low: timeout count++; at LOCK_TIMEOUT -> lock=0,
//   count=0, arbitrate normally from next cycle. Count clears whenever owner is valid.
//  START: tx_start=1 exactly one cycle; go WAIT_BUSY.
//  WAIT_BUSY: wait tx_ready=0 (uart_tx accepted); go WAIT_DONE. No timeout.
//  WAIT_DONE: wait tx_ready=1; go IDLE. Next byte accepted no earlier than the IDLE cycle after.
//  Lock update on ack: req_last=1 or burst count+1==MAX_BURST -> lock=0, burst=0;
//   else lock=1, burst++. Burst-cap release mid-message is deliberate: message resumes in a later grant.
//  req_ack one-hot or zero; never two acks closer than 4 cycles. tx_start never high unless previous
//   cycle state was IDLE with tx_ready=1.
//  Simultaneous: all valid, unlocked -> strictly rotating service. Valid dropping in the ack cycle is harmless.
//  grant_id/tx_data hold their values in IDLE until next grant.
// TESTING
//  Single requester 0 sends 0x41 (last=1), tx model ready drop after 2 cycles -> one ack, one tx_start, tx_data=0x41.
//  Req0 and req1 valid, single-byte messages -> line order 0,1,0,1; grant_id alternates; pointer wraps 1->0.
//  Req0 4-byte message (last on 4th), req1 valid throughout -> bytes 0..3 of req0 contiguous, then req1.
//  MAX_BURST=2, req0 5-byte message, req1 valid -> order r0,r0,r1,r0,r0,r1,r0.
//  Req0 locked then valid low 64 cycles while req1 valid -> lock drops, req1 granted; 63 cycles -> still blocked.
//  rst_n low during WAIT_BUSY -> outputs zero same cycle; after release first grant goes to requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Lets N_REQ byte sources share one uart_tx. Sources are served round-robin.
//   A multi-byte message is kept together on the line by a lock on the current
//   owner. Two limits stop one owner from starving the others: a burst cap on
//   back-to-back bytes, and a timeout on a locked owner that has gone quiet.
//
// Ports
//   clk        system clock, everything on posedge
//   rst_n      asynchronous active-low reset
//   req_valid  per requester: a byte is waiting on req_data
//   req_data   byte of requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last   per requester: the waiting byte ends its message
//   req_ack    one-cycle pulse; the acked requester's byte has been captured
//   tx_ready   uart_tx idle (high) / transmitting (low)
//   tx_start   one-cycle start pulse to uart_tx
//   tx_data    captured byte for uart_tx, held until the next grant
//   busy       high in every state except IDLE
//   grant_id   index of the current or most recent owner
module uart_tx_arbiter #(
   parameter  int N_REQ        = 2,
   parameter  int DATA_WIDTH   = 8,
   parameter  int MAX_BURST    = 16,
   parameter  int LOCK_TIMEOUT = 64,
   localparam int ID_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [N_REQ-1:0]            req_last,
   output logic [N_REQ-1:0]            req_ack,
   input  logic                        tx_ready,
   output logic                        tx_start,
   output logic [DATA_WIDTH-1:0]       tx_data,
   output logic                        busy,
   output logic [ID_W-1:0]             grant_id
);

   localparam int BURST_W = $clog2(MAX_BURST + 1);
   localparam int TO_W    = $clog2(LOCK_TIMEOUT + 1);

   localparam logic [ID_W-1:0]    PTR_LAST   = ID_W'(N_REQ - 1);
   localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
   localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(LOCK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   state_t state, state_nxt;

   logic [ID_W-1:0]       rr_ptr;
   logic                  lock;
   logic [BURST_W-1:0]    burst_cnt;
   logic [TO_W-1:0]       to_cnt;

   logic                  lo_found, hi_found;
   logic [ID_W-1:0]       lo_idx, hi_idx, winner;
   logic [ID_W-1:0]       sel_id;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_last;
   logic [N_REQ-1:0]      ack_vec;
   logic                  owner_valid;
   logic                  take;

   // Round-robin pick: the lowest valid index at or above the pointer wins;
   // if none, wrap around to the lowest valid index overall. The loop runs
   // downward so the final assignment is the lowest matching index.
   always_comb begin
      lo_found = 1'b0;
      lo_idx   = '0;
      hi_found = 1'b0;
      hi_idx   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            lo_found = 1'b1;
            lo_idx   = ID_W'(i);
         end
         if (req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
            hi_found = 1'b1;
            hi_idx   = ID_W'(i);
         end
      end
      winner = hi_found ? hi_idx : lo_idx;
   end

   // While locked only the owner is eligible; everyone else is ignored.
   assign owner_valid = req_valid[grant_id];
   assign sel_id      = lock ? grant_id : winner;
   assign take        = (state == S_IDLE) && tx_ready && (lock ? owner_valid : lo_found);
   assign busy        = (state != S_IDLE);

   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      ack_vec  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (ID_W'(i) == sel_id) begin
            sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            sel_last = req_last[i];
         end
      end
      ack_vec[sel_id] = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (take) state_nxt = S_START;
         S_START:     state_nxt = S_WAIT_BUSY;
         S_WAIT_BUSY: if (!tx_ready) state_nxt = S_WAIT_DONE;
         S_WAIT_DONE: if (tx_ready) state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         tx_start  <= 1'b0;
         tx_data   <= '0;
         req_ack   <= '0;
         grant_id  <= '0;
         rr_ptr    <= '0;
         lock      <= 1'b0;
         burst_cnt <= '0;
         to_cnt    <= '0;
      end else begin
         state    <= state_nxt;
         // Start and ack are both issued in the START cycle; the byte itself
         // was captured on the granting edge.
         tx_start <= take;
         req_ack  <= take ? ack_vec : '0;

         if (take) begin
            tx_data  <= sel_data;
            grant_id <= sel_id;
            to_cnt   <= '0;
            if (!lock) rr_ptr <= (winner == PTR_LAST) ? '0 : winner + 1'b1;
            // Hitting the burst cap drops the lock even mid-message; the rest
            // of that message goes out in a later grant.
            if (sel_last || (burst_cnt == BURST_LAST)) begin
               lock      <= 1'b0;
               burst_cnt <= '0;
            end else begin
               lock      <= 1'b1;
               burst_cnt <= burst_cnt + 1'b1;
            end
         end else if ((state == S_IDLE) && lock) begin
            if (owner_valid) begin
               to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
               // Quiet owner loses the lock; its burst count goes with it so
               // the next owner starts with a full burst allowance.
               lock      <= 1'b0;
               to_cnt    <= '0;
               burst_cnt <= '0;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

   localparam int MAXB = 4;
   localparam int LTO  = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = '0;
   logic [15:0] req_data = '0;
   logic [1:0]  req_last = '0;
   logic [1:0]  req_ack;
   logic        tx_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        busy;
   logic [0:0]  grant_id;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .N_REQ(2), .DATA_WIDTH(8), .MAX_BURST(MAXB), .LOCK_TIMEOUT(LTO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ack(req_ack), .tx_ready(tx_ready),
      .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .grant_id(grant_id)
   );

   // uart_tx stand-in: ready drops 2 cycles after start, stays low 5 cycles.
   int m_cnt = 0;
   always @(posedge clk) begin
      if (tx_start) m_cnt <= 7;
      else if (m_cnt > 0) m_cnt <= m_cnt - 1;
   end
   assign tx_ready = !((m_cnt >= 1) && (m_cnt <= 5));

   // Requesters: each presents the head of its byte queue, pops on ack.
   typedef struct packed { logic [7:0] d; logic last; } rbyte_t;
   rbyte_t rq0[$];
   rbyte_t rq1[$];

   always @(posedge clk) begin
      #1;
      if (req_ack[0] && rq0.size() > 0) void'(rq0.pop_front());
      if (req_ack[1] && rq1.size() > 0) void'(rq1.pop_front());
      req_valid[0]   = (rq0.size() > 0);
      req_data[7:0]  = (rq0.size() > 0) ? rq0[0].d : 8'h00;
      req_last[0]    = (rq0.size() > 0) ? rq0[0].last : 1'b0;
      req_valid[1]   = (rq1.size() > 0);
      req_data[15:8] = (rq1.size() > 0) ? rq1[0].d : 8'h00;
      req_last[1]    = (rq1.size() > 0) ? rq1[0].last : 1'b0;
   end

   // Scoreboard of expected line traffic; run >= 0 also checks how many
   // IDLE cycles preceded that start.
   typedef struct { logic id; logic [7:0] d; int run; } exp_t;
   exp_t expq[$];

   int idle_run = 0;
   int last_run = 0;
   int cyc      = 0;
   int last_ack = -100;
   exp_t e;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         idle_run = 0;
      end else begin
         if (busy) begin
            if (idle_run > 0) last_run = idle_run;
            idle_run = 0;
         end else begin
            idle_run++;
         end
         if (tx_start) begin
            total++;
            if (expq.size() == 0) begin
               bad++;
               $display("FAIL start_unexpected id=%0d data=%02h (none expected)", grant_id, tx_data);
            end else begin
               e = expq.pop_front();
               if ((grant_id !== e.id) || (tx_data !== e.d) || ((e.run >= 0) && (last_run != e.run))) begin
                  bad++;
                  $display("FAIL start got id=%0d data=%02h idle=%0d want id=%0d data=%02h idle=%0d",
                           grant_id, tx_data, last_run, e.id, e.d, e.run);
               end
            end
         end
         if (req_ack !== 2'b00) begin
            total++;
            if ((req_ack !== (2'b01 << grant_id)) || (cyc - last_ack < 4)) begin
               bad++;
               $display("FAIL ack got=%b owner=%0d gap=%0d want one-hot owner gap>=4",
                        req_ack, grant_id, cyc - last_ack);
            end
            last_ack = cyc;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, want);
      end
   endtask

   task automatic expect_byte(input logic id, input logic [7:0] d, input int run);
      exp_t x;
      x.id = id; x.d = d; x.run = run;
      expq.push_back(x);
   endtask

   task automatic push(input int r, input logic [7:0] d, input logic last);
      rbyte_t b;
      b.d = d; b.last = last;
      if (r == 0) rq0.push_back(b);
      else rq1.push_back(b);
   endtask

   task automatic wait_drain(input string nm, input int budget);
      int n = 0;
      while (!((rq0.size() == 0) && (rq1.size() == 0) && (expq.size() == 0) && !busy && (m_cnt == 0))
             && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= budget) begin
         bad++;
         $display("FAIL %s_drain got pending=%0d want 0 within %0d cycles", nm, expq.size(), budget);
         expq.delete(); rq0.delete(); rq1.delete();
      end
   endtask

   task automatic wait_start(input string nm);
      int n = 0;
      while (!tx_start && (n < 50)) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!tx_start) begin
         bad++;
         $display("FAIL %s_start got no tx_start want one within 50 cycles", nm);
      end
   endtask

   typedef struct { logic [1:0] mask; logic [7:0] d0; logic [7:0] d1; logic first; } vec_t;
   vec_t vt[8];

   initial begin
      // mask, byte of req0, byte of req1, which one the rotating pointer favours
      vt[0] = '{2'b01, 8'h41, 8'h00, 1'b0};
      vt[1] = '{2'b11, 8'h52, 8'hA3, 1'b1};
      vt[2] = '{2'b10, 8'h00, 8'h5C, 1'b1};
      vt[3] = '{2'b11, 8'h0F, 8'hF0, 1'b0};
      vt[4] = '{2'b10, 8'h00, 8'h99, 1'b1};
      vt[5] = '{2'b01, 8'hC3, 8'h00, 1'b0};
      vt[6] = '{2'b11, 8'h66, 8'h77, 1'b1};
      vt[7] = '{2'b10, 8'h00, 8'h18, 1'b1};

      repeat (2) @(negedge clk);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data",  tx_data,  0);
      chk("rst_req_ack",  req_ack,  0);
      chk("rst_busy",     busy,     0);
      chk("rst_grant_id", grant_id, 0);
      rst_n = 1'b1;

      // Single-byte messages, rotation and pointer wrap.
      for (int v = 0; v < 8; v++) begin
         @(negedge clk);
         if (vt[v].mask == 2'b11) begin
            if (vt[v].first == 1'b0) begin
               expect_byte(1'b0, vt[v].d0, -1);
               expect_byte(1'b1, vt[v].d1, -1);
            end else begin
               expect_byte(1'b1, vt[v].d1, -1);
               expect_byte(1'b0, vt[v].d0, -1);
            end
         end else if (vt[v].mask[0]) begin
            expect_byte(1'b0, vt[v].d0, -1);
         end else begin
            expect_byte(1'b1, vt[v].d1, -1);
         end
         if (vt[v].mask[0]) push(0, vt[v].d0, 1'b1);
         if (vt[v].mask[1]) push(1, vt[v].d1, 1'b1);
         wait_drain("vec", 200);
      end

      // 4-byte message from req0 stays contiguous while req1 waits.
      @(negedge clk);
      for (int i = 0; i < 4; i++) expect_byte(1'b0, 8'h10 + 8'(i), -1);
      expect_byte(1'b1, 8'h20, -1);
      for (int i = 0; i < 4; i++) push(0, 8'h10 + 8'(i), i == 3);
      push(1, 8'h20, 1'b1);
      wait_drain("msg4", 300);

      // Burst cap of 4 splits a 10-byte message from req0.
      @(negedge clk);
      for (int i = 0; i < 4; i++) expect_byte(1'b0, 8'h30 + 8'(i), -1);
      expect_byte(1'b1, 8'h50, -1);
      for (int i = 4; i < 8; i++) expect_byte(1'b0, 8'h30 + 8'(i), -1);
      expect_byte(1'b1, 8'h51, -1);
      expect_byte(1'b0, 8'h38, -1);
      expect_byte(1'b0, 8'h39, -1);
      expect_byte(1'b1, 8'h52, -1);
      for (int i = 0; i < 10; i++) push(0, 8'h30 + 8'(i), i == 9);
      for (int i = 0; i < 3; i++) push(1, 8'h50 + 8'(i), 1'b1);
      wait_drain("burst", 800);

      // Locked owner silent for LOCK_TIMEOUT idle cycles: req1 gets in.
      @(negedge clk);
      expect_byte(1'b0, 8'h60, -1);
      expect_byte(1'b1, 8'h61, LTO + 1);
      push(0, 8'h60, 1'b0);
      wait_start("lock64");
      push(1, 8'h61, 1'b1);
      wait_drain("lock64", 400);

      // Owner returns after LOCK_TIMEOUT-1 idle cycles: still holds the line.
      @(negedge clk);
      expect_byte(1'b0, 8'h62, -1);
      expect_byte(1'b0, 8'h64, LTO);
      expect_byte(1'b1, 8'h63, -1);
      push(0, 8'h62, 1'b0);
      wait_start("lock63");
      push(1, 8'h63, 1'b1);
      for (int n = 0; busy && (n < 50); n++) @(negedge clk);
      repeat (LTO - 2) @(negedge clk);
      push(0, 8'h64, 1'b1);
      wait_drain("lock63", 400);

      // Reset in WAIT_BUSY aborts at once; pointer restarts at requester 0.
      @(negedge clk);
      expect_byte(1'b0, 8'h5A, -1);
      push(0, 8'h5A, 1'b1);
      wait_start("rst_mid");
      @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tx_start", tx_start, 0);
      chk("mid_rst_tx_data",  tx_data,  0);
      chk("mid_rst_req_ack",  req_ack,  0);
      chk("mid_rst_busy",     busy,     0);
      chk("mid_rst_grant_id", grant_id, 0);
      expect_byte(1'b0, 8'h70, -1);
      expect_byte(1'b1, 8'h71, -1);
      push(0, 8'h70, 1'b1);
      push(1, 8'h71, 1'b1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_drain("post_rst", 300);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got no finish want finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
